// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared encodings for the multicycle MIPS controller:
//               opcodes, function fields, ALU controls, ALU ops, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Instruction opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function fields (instr[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALU control codes seen by the datapath
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Coarse ALU request from the FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Controller states; codes 12-15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Maps the FSM's ALU request plus the R-type function field
//               onto the 3-bit ALU control code. Unknown functs fall back
//               to add so the datapath never sees an undefined operation.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    // Pure combinational lookup; add is the safe default for every case
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    default:   alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule : alu_decoder
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multicycle MIPS control FSM. The state register is the only
//               flop; all outputs are decoded from it (Moore), except PC_en
//               which also folds in the ALU zero flag for taken branches.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op_code,
    input  logic [5:0] Funct,
    input  logic       zero,
    output logic       PC_en,
    output logic       IorD,
    output logic       Mem_write,
    output logic       IR_write,
    output logic       Memtoreg,
    output logic       Reg_dst,
    output logic       Reg_write,
    output logic       ALU_srcA,
    output logic [1:0] ALU_srcB,
    output logic [1:0] PC_src,
    output logic [2:0] ALU_control,
    output logic [3:0] state
);

    state_t     state_q;
    logic       pc_write;
    logic       branch;
    logic       ir_load;
    logic [1:0] alu_op;

    // State register with next-state selection; reset aborts any instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  state_q <= S_DECODE;
                S_DECODE: begin
                    case (Op_code)
                        OP_LW, OP_SW: state_q <= S_MEMADR;
                        OP_RTYPE:     state_q <= S_EXEC;
                        OP_BEQ:       state_q <= S_BRANCH;
                        OP_ADDI:      state_q <= S_ADDIEX;
                        OP_J:         state_q <= S_JUMP;
                        default:      state_q <= S_FETCH;
                    endcase
                end
                S_MEMADR: state_q <= (Op_code == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  state_q <= S_MEMWB;
                S_EXEC:   state_q <= S_ALUWB;
                S_ADDIEX: state_q <= S_ADDIWB;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    // Per-state control decode; anything not driven in a state stays 0
    always_comb begin
        IorD      = 1'b0;
        Mem_write = 1'b0;
        ir_load   = 1'b0;
        Memtoreg  = 1'b0;
        Reg_dst   = 1'b0;
        Reg_write = 1'b0;
        ALU_srcA  = 1'b0;
        ALU_srcB  = 2'b00;
        PC_src    = 2'b00;
        pc_write  = 1'b0;
        branch    = 1'b0;
        alu_op    = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                ir_load  = 1'b1;
                ALU_srcB = 2'b01;
                pc_write = 1'b1;
            end
            S_DECODE: ALU_srcB = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                ALU_srcA = 1'b1;
                ALU_srcB = 2'b10;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWR: begin
                IorD      = 1'b1;
                Mem_write = 1'b1;
            end
            S_MEMWB: begin
                Memtoreg  = 1'b1;
                Reg_write = 1'b1;
            end
            S_EXEC: begin
                ALU_srcA = 1'b1;
                alu_op   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                Reg_dst   = 1'b1;
                Reg_write = 1'b1;
            end
            S_ADDIWB: Reg_write = 1'b1;
            S_BRANCH: begin
                ALU_srcA = 1'b1;
                alu_op   = ALUOP_SUB;
                PC_src   = 2'b01;
                branch   = 1'b1;
            end
            S_JUMP: begin
                PC_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Hold PC and IR still while reset is high, even though FETCH is decoded
    always_comb begin
        IR_write = ir_load & ~reset;
        PC_en    = (pc_write & ~reset) | (branch & zero);
        state    = state_q;
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (Funct),
        .alu_control (ALU_control)
    );

endmodule : multicycle_ctrl
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl. A reference model
//               expands each opcode into its expected state trace and looks
//               up the expected control word for every state visited.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op_code;
    logic [5:0] Funct;
    logic       zero;
    logic       PC_en, IorD, Mem_write, IR_write, Memtoreg, Reg_dst, Reg_write, ALU_srcA;
    logic [1:0] ALU_srcB, PC_src;
    logic [2:0] ALU_control;
    logic [3:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .Op_code     (Op_code),
        .Funct       (Funct),
        .zero        (zero),
        .PC_en       (PC_en),
        .IorD        (IorD),
        .Mem_write   (Mem_write),
        .IR_write    (IR_write),
        .Memtoreg    (Memtoreg),
        .Reg_dst     (Reg_dst),
        .Reg_write   (Reg_write),
        .ALU_srcA    (ALU_srcA),
        .ALU_srcB    (ALU_srcB),
        .PC_src      (PC_src),
        .ALU_control (ALU_control),
        .state       (state)
    );

    always #5 clk = ~clk;

    // One comparison point
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_known(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    // R-type ALU operation by function field
    function automatic logic [2:0] funct_ctrl(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected state trace for one instruction, starting at FETCH
    function automatic void trace_of(input logic [5:0] op, ref int q[$]);
        q = {0, 1};
        case (op)
            6'b100011: q = {q, 2, 3, 4};
            6'b101011: q = {q, 2, 5};
            6'b000000: q = {q, 6, 7};
            6'b000100: q = {q, 8};
            6'b001000: q = {q, 9, 10};
            6'b000010: q = {q, 11};
            default:   ;
        endcase
    endfunction

    // Compare every output against the control word listed for state s
    task automatic check_state(input int s, input logic [5:0] fn, input logic z, input string ctx);
        logic e_iord = 0, e_mw = 0, e_irw = 0, e_m2r = 0, e_rd = 0, e_rw = 0, e_sa = 0;
        logic [1:0] e_sb = 0, e_ps = 0;
        logic [2:0] e_alu = 3'b010;
        logic pcw = 0, br = 0, alu_chk = 0;
        case (s)
            0:  begin e_irw = 1; e_sb = 2'b01; pcw = 1; alu_chk = 1; end
            1:  begin e_sb = 2'b11; alu_chk = 1; end
            2, 9: begin e_sa = 1; e_sb = 2'b10; alu_chk = 1; end
            3:  e_iord = 1;
            4:  begin e_m2r = 1; e_rw = 1; end
            5:  begin e_iord = 1; e_mw = 1; end
            6:  begin e_sa = 1; e_alu = funct_ctrl(fn); alu_chk = 1; end
            7:  begin e_rd = 1; e_rw = 1; end
            8:  begin e_sa = 1; e_alu = 3'b110; e_ps = 2'b01; br = 1; alu_chk = 1; end
            10: e_rw = 1;
            11: begin e_ps = 2'b10; pcw = 1; end
            default: ;
        endcase
        chk($sformatf("%s state", ctx), 8'(state), 8'(s));
        chk($sformatf("%s st%0d PC_en", ctx, s), 8'(PC_en), 8'(pcw | (br & z)));
        chk($sformatf("%s st%0d IorD", ctx, s), 8'(IorD), 8'(e_iord));
        chk($sformatf("%s st%0d Mem_write", ctx, s), 8'(Mem_write), 8'(e_mw));
        chk($sformatf("%s st%0d IR_write", ctx, s), 8'(IR_write), 8'(e_irw));
        chk($sformatf("%s st%0d Memtoreg", ctx, s), 8'(Memtoreg), 8'(e_m2r));
        chk($sformatf("%s st%0d Reg_dst", ctx, s), 8'(Reg_dst), 8'(e_rd));
        chk($sformatf("%s st%0d Reg_write", ctx, s), 8'(Reg_write), 8'(e_rw));
        chk($sformatf("%s st%0d ALU_srcA", ctx, s), 8'(ALU_srcA), 8'(e_sa));
        chk($sformatf("%s st%0d ALU_srcB", ctx, s), 8'(ALU_srcB), 8'(e_sb));
        chk($sformatf("%s st%0d PC_src", ctx, s), 8'(PC_src), 8'(e_ps));
        if (alu_chk)
            chk($sformatf("%s st%0d ALU_control", ctx, s), 8'(ALU_control), 8'(e_alu));
    endtask

    // Run one instruction from FETCH back to the next FETCH; zmode 2 = random zero
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode, input string ctx);
        int q[$];
        trace_of(op, q);
        foreach (q[k]) begin
            Op_code = op;
            Funct   = fn;
            zero    = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            #1;
            check_state(q[k], fn, zero, ctx);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] op, fn;
        int sel;

        reset   = 1'b1;
        Op_code = 6'b100011;
        Funct   = 6'($urandom);
        zero    = 1'b1;
        @(posedge clk);
        #1;
        // Held in reset: FETCH decode but PC/IR loads suppressed
        chk("rst state", 8'(state), 8'd0);
        chk("rst PC_en", 8'(PC_en), 8'd0);
        chk("rst IR_write", 8'(IR_write), 8'd0);
        chk("rst IorD", 8'(IorD), 8'd0);
        chk("rst ALU_srcA", 8'(ALU_srcA), 8'd0);
        chk("rst ALU_srcB", 8'(ALU_srcB), 8'd1);
        chk("rst ALU_control", 8'(ALU_control), 8'd2);
        chk("rst PC_src", 8'(PC_src), 8'd0);
        chk("rst Reg_write", 8'(Reg_write), 8'd0);
        chk("rst Mem_write", 8'(Mem_write), 8'd0);
        #3 reset = 1'b0;
        #1;
        chk("rel PC_en", 8'(PC_en), 8'd1);
        chk("rel IR_write", 8'(IR_write), 8'd1);

        // Directed instructions
        run_instr(6'b100011, 6'b000000, 2, "lw");
        run_instr(6'b101011, 6'b000000, 2, "sw");
        run_instr(6'b000000, 6'b101010, 2, "slt");
        run_instr(6'b000000, 6'b100010, 2, "sub");
        run_instr(6'b000000, 6'b100100, 2, "and");
        run_instr(6'b000000, 6'b100101, 2, "or");
        run_instr(6'b000000, 6'b100000, 2, "add");
        run_instr(6'b000000, 6'b111011, 2, "badfunct");
        run_instr(6'b000100, 6'b000000, 1, "beq_taken");
        run_instr(6'b000100, 6'b000000, 0, "beq_not");
        run_instr(6'b001000, 6'b000000, 2, "addi");
        run_instr(6'b000010, 6'b000000, 2, "j");
        run_instr(6'b111111, 6'b000000, 1, "unknown");

        // Asynchronous reset in the middle of a load's MEMRD cycle
        Op_code = 6'b100011;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
        end
        #1;
        chk("abort pre state", 8'(state), 8'd3);
        #2 reset = 1'b1;
        #1;
        chk("abort state", 8'(state), 8'd0);
        chk("abort Reg_write", 8'(Reg_write), 8'd0);
        chk("abort Mem_write", 8'(Mem_write), 8'd0);
        chk("abort PC_en", 8'(PC_en), 8'd0);
        chk("abort IR_write", 8'(IR_write), 8'd0);
        @(posedge clk);
        #1;
        chk("abort held state", 8'(state), 8'd0);
        chk("abort held Reg_write", 8'(Reg_write), 8'd0);
        #2 reset = 1'b0;
        #1;
        chk("abort rel PC_en", 8'(PC_en), 8'd1);
        chk("abort rel IR_write", 8'(IR_write), 8'd1);
        run_instr(6'b100011, 6'b000000, 2, "lw_after_abort");

        // Random instruction stream
        for (int i = 0; i < 60; i++) begin
            sel = int'($urandom_range(0, 6));
            fn  = 6'($urandom);
            if ($urandom_range(0, 1) == 1)
                fn = (sel == 0) ? 6'b101010 : 6'b100010;
            case (sel)
                0: op = 6'b000000;
                1: op = 6'b100011;
                2: op = 6'b101011;
                3: op = 6'b000100;
                4: op = 6'b001000;
                5: op = 6'b000010;
                default: begin
                    op = 6'($urandom);
                    while (is_known(op)) op = 6'($urandom);
                end
            endcase
            run_instr(op, fn, 2, $sformatf("rnd%0d_op%02h", i, op));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_multicycle_ctrl
`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: none; all encodings are fixed constants.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces FETCH state immediately.
REQ-004 Op_code  input  6  instruction opcode (instr[31:26]) from the instruction register.
REQ-005 Funct  input  6  function field (instr[5:0]) from the instruction register.
REQ-006 zero  input  1  ALU zero flag from the datapath.
REQ-007 PC_en  output  1  PC register load enable.
REQ-008 IorD  output  1  memory address select: 0=PC, 1=ALU_out.
REQ-009 Mem_write  output  1  data memory write enable.
REQ-010 IR_write  output  1  instruction register load enable.
REQ-011 Memtoreg  output  1  register write data select: 0=ALU_out, 1=mem data.
REQ-012 Reg_dst  output  1  write register select: 0=rt, 1=rd.
REQ-013 Reg_write  output  1  register file write enable.
REQ-014 ALU_srcA  output  1  0=PC, 1=reg A.
REQ-015 ALU_srcB  output  2  00=reg B, 01=constant 4, 10=SignImm, 11=SignImm<<2.
REQ-016 PC_src  output  2  00=ALU result, 01=ALU_out, 10=jump target.
REQ-017 ALU_control  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-018 state  output  4  current state encoding, for debug/test observation.

Function
REQ-019 Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
REQ-020 States: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11; codes 12-15 unreachable and return to FETCH.
REQ-021 Transitions: FETCH->DECODE; DECODE->MEMADR (lw/sw), EXEC (R-type), BRANCH (beq), ADDIEX (addi), JUMP (j), FETCH (any other opcode).
REQ-022 MEMADR->MEMRD (lw) or MEMWR (sw); MEMRD->MEMWB; EXEC->ALUWB; ADDIEX->ADDIWB; MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP ->FETCH.
REQ-023 Cycle counts per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown opcode 2.
REQ-024 Moore outputs: every output except PC_en depends only on state; signals not listed for a state are 0.
REQ-025 FETCH: IorD=0, IR_write=1, ALU_srcA=0, ALU_srcB=01, ALU_control=010, PC_src=00, PC_write=1.
REQ-026 DECODE: ALU_srcA=0, ALU_srcB=11, ALU_control=010 (branch target precompute).
REQ-027 MEMADR/ADDIEX: ALU_srcA=1, ALU_srcB=10, ALU_control=010.
REQ-028 MEMRD: IorD=1; MEMWR: IorD=1, Mem_write=1; MEMWB: Reg_dst=0, Memtoreg=1, Reg_write=1.
REQ-029 EXEC: ALU_srcA=1, ALU_srcB=00, ALU_control from Funct (add/sub/and/or/slt); unknown Funct yields 010.
REQ-030 ALUWB: Reg_dst=1, Memtoreg=0, Reg_write=1; ADDIWB: Reg_dst=0, Memtoreg=0, Reg_write=1.
REQ-031 BRANCH: ALU_srcA=1, ALU_srcB=00, ALU_control=110, PC_src=01, Branch=1.
REQ-032 JUMP: PC_src=10, PC_write=1.
REQ-033 PC_en = PC_write | (Branch & zero); combinational, the only Mealy output.
REQ-034 Mem_write and Reg_write are never both 1 in one cycle; IR_write is 1 only in FETCH.

Reset
REQ-035 While reset is high, state=FETCH and outputs equal FETCH values except PC_en=0 and IR_write=0.
REQ-036 Reset asserted mid-instruction aborts it; no pending Reg_write or Mem_write occurs after release.
REQ-037 First rising edge after reset release performs a full FETCH cycle.

Structure
REQ-038 Package mips_pkg holds opcode, Funct, ALU_control and state encoding constants.
REQ-039 Sub-module alu_decoder maps (ALU_op 2b, Funct) to ALU_control; FSM drives ALU_op 00=add, 01=sub, 10=use Funct.
REQ-040 The state register is the only sequential element.

Verification
REQ-041 Reset high mid-MEMRD -> state=0 asynchronously, Reg_write=0; release -> FETCH with PC_en=1, IR_write=1.
REQ-042 Op_code=100011 -> states 0,1,2,3,4,0; Reg_write=1 and Memtoreg=1 only in state 4.
REQ-043 Op_code=101011 -> states 0,1,2,5,0; Mem_write=1 only in state 5 with IorD=1.
REQ-044 Op_code=000000, Funct=101010 -> states 0,1,6,7,0; ALU_control=111 in EXEC; Reg_dst=1 in ALUWB.
REQ-045 Op_code=000100 in BRANCH with zero=1 -> PC_en=1, PC_src=01; with zero=0 -> PC_en=0.
REQ-046 Op_code=111111 -> states 0,1,0; no Reg_write, Mem_write or PC_en outside FETCH.
